circle_hit_pipe: RTL and testbench
==================================

Name: circle_hit_pipe

Overview:
Pipelined, multi-circle point-in-circle tester for the overlay/pixel path. Each accepted pixel coordinate is tested against a programmable table of NUM_CIRCLES circles (centre, radius, enable). The block returns a per-circle hit mask, an any-hit flag and the lowest-index hit after a fixed 3-cycle latency, with valid/ready flow control. It supersedes the single-circle, unregistered-radius tester and is fully reset.

Parameters:
COORD_W, 12, width of coordinates and radius (unsigned)
NUM_CIRCLES, 4, number of circle table entries (1..16)
INCLUSIVE, 1, 1: hit when d^2 <= r^2; 0: hit when d^2 < r^2
IDX_W (localparam), max(1,clog2(NUM_CIRCLES)), index width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe
cfg_idx  in  IDX_W  entry to write
cfg_x  in  COORD_W  centre X
cfg_y  in  COORD_W  centre Y
cfg_r  in  COORD_W  radius
cfg_en  in  1  entry enable
cfg_rin  in  COORD_W  inner radius (present only with CIRCLE_RING_EN)
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_x  in  COORD_W  pixel X
in_y  in  COORD_W  pixel Y
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_hit_mask  out  NUM_CIRCLES  bit i = hit on circle i
out_any  out  1  OR of out_hit_mask
out_first_idx  out  IDX_W  lowest set bit of mask; 0 when none
out_x, out_y  out  COORD_W each  pixel coordinate passed through

Behaviour:
- Reset (async, resetn=0): all table entries cleared (x=y=r=0, en=0, r2=0); all stage valids 0; out_valid=0, out_hit_mask=0, out_any=0, out_first_idx=0, out_x=out_y=0. in_ready=1 after reset. Reset mid-operation discards in-flight pixels.
- Table write: on clk with cfg_we=1 and cfg_idx<NUM_CIRCLES, entry stores x,y,en and r2=cfg_r*cfg_r (2*COORD_W bits). cfg_idx>=NUM_CIRCLES ignored. Visible to pixels accepted on the next cycle or later.
- Snapshot rule: a pixel's per-circle r2/centre/en are captured at acceptance and carried down the pipeline; later writes never affect in-flight pixels. A write and acceptance in the same cycle: pixel uses the old entry.
- Pipeline, single global advance = !out_valid || out_ready; in_ready = advance.
  S1 (accept): dx_i=|in_x-cx_i|, dy_i=|in_y-cy_i| (COORD_W, exact via compare-then-subtract; equal gives 0); register r2_i, en_i, in_x, in_y.
  S2: sq registers dx_i^2, dy_i^2 (2*COORD_W each).
  S3: sum = dx^2+dy^2 at 2*COORD_W+1 bits (no overflow); hit_i = en_i && (sum <= r2_i or sum < r2_i per INCLUSIVE). Register mask, any, first_idx, out_x/y, out_valid.
- Latency: accepted in cycle t -> out_valid in cycle t+3 when never stalled. Throughput one pixel/clk.
- Stall: out_valid && !out_ready freezes all stages and in_ready=0; outputs held stable; no pixel dropped or duplicated. Bubbles (in_valid=0) propagate as invalid stages.
- Disabled entry or r=0 with INCLUSIVE=0: never hits. r=0 with INCLUSIVE=1: hits only exact centre.

Optional Feature:
CIRCLE_RING_EN: defined -> cfg_rin port exists; each entry also stores rin2=cfg_rin^2, snapshotted like r2; hit_i additionally requires sum > rin2 (annulus; rin=0 behaves as full disc except centre excluded only if rin2>=sum, i.e. centre excluded since 0>0 false). rin>=r gives no hits. Undefined -> no cfg_rin port, no inner test, no rin2 storage.

Test Plan:
- Reset, write entry0 (100,100,r=10,en=1), send (106,108) -> after 3 clk mask=0001, any=1, first_idx=0 (d^2=100, INCLUSIVE=1); same with INCLUSIVE=0 -> mask=0000.
- Entries 1 (50,50,r=5) and 3 (52,50,r=5) enabled; pixel (51,50) -> mask=1010, first_idx=1; pixel (0,0) -> mask=0000, first_idx=0, any=0.
- Extremes COORD_W=12: entry (0,0,r=4095), pixel (4095,4095) -> sum=33538050 > r2=16769025 -> no hit; no overflow.
- Back-to-back 8 pixels, out_ready low cycles 2-4 -> in_ready low those cycles, outputs held, all 8 results in order, none lost.
- Rewrite entry0 radius 10->1 in same cycle as pixel (105,100) accepted -> that pixel hits (old r2); next identical pixel misses.
- Assert resetn mid-stream with 3 pixels in flight -> out_valid=0 immediately, no stale result after release; with CIRCLE_RING_EN, rin=5,r=10: pixel d=3 miss, d=7 hit.

Source files
------------

// File: rtl/circle_hit_pipe_if.sv
// -----------------------------------------------------------------------------
// circle_hit_pipe_if
// Bundles the circle-table configuration port, the pixel input stream and the
// hit-result output stream of circle_hit_pipe.
//   cfg_we/cfg_idx/cfg_x/cfg_y/cfg_r/cfg_en : circle table write port
//   cfg_rin                                 : inner radius (CIRCLE_RING_EN only)
//   in_valid/in_ready/in_x/in_y             : pixel stream into the block
//   out_valid/out_ready/out_hit_mask/out_any/out_first_idx/out_x/out_y
//                                           : result stream out of the block
// modport master : the side that programs the table, sends pixels and consumes
//                  results.
// modport slave  : circle_hit_pipe itself.
// Optional feature macro: CIRCLE_RING_EN (adds cfg_rin).
// -----------------------------------------------------------------------------
interface circle_hit_pipe_if #(
  parameter int COORD_W     = 12,
  parameter int NUM_CIRCLES = 4
);
  localparam int IDX_W = (NUM_CIRCLES > 1) ? $clog2(NUM_CIRCLES) : 1;

  logic                   cfg_we;
  logic [IDX_W-1:0]       cfg_idx;
  logic [COORD_W-1:0]     cfg_x;
  logic [COORD_W-1:0]     cfg_y;
  logic [COORD_W-1:0]     cfg_r;
  logic                   cfg_en;
`ifdef CIRCLE_RING_EN
  logic [COORD_W-1:0]     cfg_rin;
`endif
  logic                   in_valid;
  logic                   in_ready;
  logic [COORD_W-1:0]     in_x;
  logic [COORD_W-1:0]     in_y;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_CIRCLES-1:0] out_hit_mask;
  logic                   out_any;
  logic [IDX_W-1:0]       out_first_idx;
  logic [COORD_W-1:0]     out_x;
  logic [COORD_W-1:0]     out_y;

`ifdef CIRCLE_RING_EN
  modport master (
    output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_r, cfg_en, cfg_rin,
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_hit_mask, out_any, out_first_idx, out_x, out_y
  );
  modport slave (
    input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_r, cfg_en, cfg_rin,
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_hit_mask, out_any, out_first_idx, out_x, out_y
  );
`else
  modport master (
    output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_r, cfg_en,
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_hit_mask, out_any, out_first_idx, out_x, out_y
  );
  modport slave (
    input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_r, cfg_en,
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_hit_mask, out_any, out_first_idx, out_x, out_y
  );
`endif
endinterface

// File: rtl/circle_hit_pipe.sv
// -----------------------------------------------------------------------------
// circle_hit_pipe
// Three-stage point-in-circle tester. Every accepted pixel is compared against
// a table of NUM_CIRCLES circles (centre, squared radius, enable) and produces
// a per-circle hit mask, an any-hit flag and the lowest hit index, three
// cycles after acceptance when the output is not back-pressured.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset, clears table and pipeline
//   bus    : circle_hit_pipe_if.slave (table write, pixel in, result out)
// Optional feature macro: CIRCLE_RING_EN -- each entry also holds an inner
// radius and a hit additionally requires the distance to lie outside it.
// -----------------------------------------------------------------------------
module circle_hit_pipe #(
  parameter int COORD_W     = 12,
  parameter int NUM_CIRCLES = 4,
  parameter int INCLUSIVE   = 1
) (
  input logic               clk,
  input logic               resetn,
  circle_hit_pipe_if.slave  bus
);
  localparam int IDX_W = (NUM_CIRCLES > 1) ? $clog2(NUM_CIRCLES) : 1;
  localparam int SQ_W  = 2 * COORD_W;
  localparam int SUM_W = SQ_W + 1;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SQ_W-1:0]    sq_t;

  // Circle table
  coord_t                 r_cx [NUM_CIRCLES];
  coord_t                 r_cy [NUM_CIRCLES];
  sq_t                    r_r2 [NUM_CIRCLES];
  logic [NUM_CIRCLES-1:0] r_en;

  // Stage 1: absolute distances plus snapshot of the entries used
  logic                   r_s1_valid;
  coord_t                 r_s1_dx [NUM_CIRCLES];
  coord_t                 r_s1_dy [NUM_CIRCLES];
  sq_t                    r_s1_r2 [NUM_CIRCLES];
  logic [NUM_CIRCLES-1:0] r_s1_en;
  coord_t                 r_s1_x, r_s1_y;

  // Stage 2: squared distances
  logic                   r_s2_valid;
  sq_t                    r_s2_dx2 [NUM_CIRCLES];
  sq_t                    r_s2_dy2 [NUM_CIRCLES];
  sq_t                    r_s2_r2  [NUM_CIRCLES];
  logic [NUM_CIRCLES-1:0] r_s2_en;
  coord_t                 r_s2_x, r_s2_y;

`ifdef CIRCLE_RING_EN
  sq_t                    r_rin2    [NUM_CIRCLES];
  sq_t                    r_s1_rin2 [NUM_CIRCLES];
  sq_t                    r_s2_rin2 [NUM_CIRCLES];
`endif

  // Stage 3: registered results
  logic                   r_out_valid;
  logic [NUM_CIRCLES-1:0] r_out_mask;
  logic                   r_out_any;
  logic [IDX_W-1:0]       r_out_first;
  coord_t                 r_out_x, r_out_y;

  coord_t                 w_dx [NUM_CIRCLES];
  coord_t                 w_dy [NUM_CIRCLES];
  logic [SUM_W-1:0]       w_sum [NUM_CIRCLES];
  logic [NUM_CIRCLES-1:0] w_hit;
  logic [IDX_W-1:0]       w_first;
  logic                   w_advance;

  // One global enable: the whole pipe moves only when the result register is
  // empty or being consumed, so a stall freezes every stage in lockstep.
  assign w_advance = !r_out_valid || bus.out_ready;

  // NOTE: the table is built from flops rather than a RAM macro, so it takes
  // the asynchronous reset like every other register and powers up cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_en <= '0;
      for (int i = 0; i < NUM_CIRCLES; i++) begin
        r_cx[i]   <= '0;
        r_cy[i]   <= '0;
        r_r2[i]   <= '0;
`ifdef CIRCLE_RING_EN
        r_rin2[i] <= '0;
`endif
      end
    end else if (bus.cfg_we) begin
      // Matching against every legal index drops out-of-range writes.
      for (int i = 0; i < NUM_CIRCLES; i++) begin
        if (bus.cfg_idx == IDX_W'(i)) begin
          r_cx[i]   <= bus.cfg_x;
          r_cy[i]   <= bus.cfg_y;
          r_en[i]   <= bus.cfg_en;
          r_r2[i]   <= sq_t'(bus.cfg_r) * sq_t'(bus.cfg_r);
`ifdef CIRCLE_RING_EN
          r_rin2[i] <= sq_t'(bus.cfg_rin) * sq_t'(bus.cfg_rin);
`endif
        end
      end
    end
  end

  // Compare-then-subtract keeps |a-b| exact in COORD_W bits.
  always_comb begin
    for (int i = 0; i < NUM_CIRCLES; i++) begin
      w_dx[i] = (bus.in_x >= r_cx[i]) ? (bus.in_x - r_cx[i]) : (r_cx[i] - bus.in_x);
      w_dy[i] = (bus.in_y >= r_cy[i]) ? (bus.in_y - r_cy[i]) : (r_cy[i] - bus.in_y);
    end
  end

  // NOTE: combinational outputs get a default before any conditional update,
  // so no path leaves them unassigned and no latch is inferred.
  always_comb begin
    w_hit   = '0;
    w_first = '0;
    for (int i = 0; i < NUM_CIRCLES; i++) begin
      // One extra bit keeps dx^2+dy^2 exact for extreme coordinates.
      w_sum[i] = SUM_W'(r_s2_dx2[i]) + SUM_W'(r_s2_dy2[i]);
      if (INCLUSIVE != 0) w_hit[i] = r_s2_en[i] && (w_sum[i] <= SUM_W'(r_s2_r2[i]));
      else                w_hit[i] = r_s2_en[i] && (w_sum[i] <  SUM_W'(r_s2_r2[i]));
`ifdef CIRCLE_RING_EN
      w_hit[i] = w_hit[i] && (w_sum[i] > SUM_W'(r_s2_rin2[i]));
`endif
    end
    // Scan downwards so the lowest set bit wins.
    for (int i = NUM_CIRCLES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_first = IDX_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage reads
  // the previous-cycle value of the stage before it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid  <= 1'b0;
      r_s1_en     <= '0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_en     <= '0;
      r_s2_x      <= '0;
      r_s2_y      <= '0;
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_out_any   <= 1'b0;
      r_out_first <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      for (int i = 0; i < NUM_CIRCLES; i++) begin
        r_s1_dx[i]  <= '0;
        r_s1_dy[i]  <= '0;
        r_s1_r2[i]  <= '0;
        r_s2_dx2[i] <= '0;
        r_s2_dy2[i] <= '0;
        r_s2_r2[i]  <= '0;
`ifdef CIRCLE_RING_EN
        r_s1_rin2[i] <= '0;
        r_s2_rin2[i] <= '0;
`endif
      end
    end else if (w_advance) begin
      // Stage 1 snapshots the table, so later writes cannot reach this pixel.
      r_s1_valid <= bus.in_valid;
      r_s1_en    <= r_en;
      r_s1_x     <= bus.in_x;
      r_s1_y     <= bus.in_y;
      r_s2_valid <= r_s1_valid;
      r_s2_en    <= r_s1_en;
      r_s2_x     <= r_s1_x;
      r_s2_y     <= r_s1_y;
      for (int i = 0; i < NUM_CIRCLES; i++) begin
        r_s1_dx[i]  <= w_dx[i];
        r_s1_dy[i]  <= w_dy[i];
        r_s1_r2[i]  <= r_r2[i];
        r_s2_dx2[i] <= sq_t'(r_s1_dx[i]) * sq_t'(r_s1_dx[i]);
        r_s2_dy2[i] <= sq_t'(r_s1_dy[i]) * sq_t'(r_s1_dy[i]);
        r_s2_r2[i]  <= r_s1_r2[i];
`ifdef CIRCLE_RING_EN
        r_s1_rin2[i] <= r_rin2[i];
        r_s2_rin2[i] <= r_s1_rin2[i];
`endif
      end
      r_out_valid <= r_s2_valid;
      r_out_mask  <= w_hit;
      r_out_any   <= |w_hit;
      r_out_first <= w_first;
      r_out_x     <= r_s2_x;
      r_out_y     <= r_s2_y;
    end
  end

  assign bus.in_ready      = w_advance;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_hit_mask  = r_out_mask;
  assign bus.out_any       = r_out_any;
  assign bus.out_first_idx = r_out_first;
  assign bus.out_x         = r_out_x;
  assign bus.out_y         = r_out_y;
endmodule

// File: tb/tb_circle_hit_pipe.sv
// -----------------------------------------------------------------------------
// tb_circle_hit_pipe
// Drives two circle_hit_pipe instances (INCLUSIVE=1 and INCLUSIVE=0) with the
// same table writes and pixels. A behavioural model computes each accepted
// pixel's expected hit masks from plain integer geometry; a queue holds the
// expected results in acceptance order. Directed cases cover the documented
// corner points, then randomized traffic with back-pressure runs against the
// model. Macro CIRCLE_RING_EN enables the annulus variant.
// -----------------------------------------------------------------------------
module tb_circle_hit_pipe;
  localparam int CW = 12;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_idx = '0;
  logic [CW-1:0] cfg_x = '0, cfg_y = '0, cfg_r = '0, cfg_rin = '0;
  logic          cfg_en = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_x = '0, in_y = '0;
  logic          out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  circle_hit_pipe_if #(.COORD_W(CW), .NUM_CIRCLES(NC)) if_inc ();
  circle_hit_pipe_if #(.COORD_W(CW), .NUM_CIRCLES(NC)) if_exc ();

  assign if_inc.cfg_we = cfg_we;   assign if_exc.cfg_we = cfg_we;
  assign if_inc.cfg_idx = cfg_idx; assign if_exc.cfg_idx = cfg_idx;
  assign if_inc.cfg_x = cfg_x;     assign if_exc.cfg_x = cfg_x;
  assign if_inc.cfg_y = cfg_y;     assign if_exc.cfg_y = cfg_y;
  assign if_inc.cfg_r = cfg_r;     assign if_exc.cfg_r = cfg_r;
  assign if_inc.cfg_en = cfg_en;   assign if_exc.cfg_en = cfg_en;
`ifdef CIRCLE_RING_EN
  assign if_inc.cfg_rin = cfg_rin; assign if_exc.cfg_rin = cfg_rin;
`endif
  assign if_inc.in_valid = in_valid;   assign if_exc.in_valid = in_valid;
  assign if_inc.in_x = in_x;           assign if_exc.in_x = in_x;
  assign if_inc.in_y = in_y;           assign if_exc.in_y = in_y;
  assign if_inc.out_ready = out_ready; assign if_exc.out_ready = out_ready;

  circle_hit_pipe #(.COORD_W(CW), .NUM_CIRCLES(NC), .INCLUSIVE(1)) u_dut_inc (
    .clk(clk), .resetn(resetn), .bus(if_inc.slave));
  circle_hit_pipe #(.COORD_W(CW), .NUM_CIRCLES(NC), .INCLUSIVE(0)) u_dut_exc (
    .clk(clk), .resetn(resetn), .bus(if_exc.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_cx [NC], m_cy [NC], m_r [NC], m_rin [NC];
  bit          m_en [NC];

  typedef struct {
    logic [NC-1:0] mask_inc;
    logic [NC-1:0] mask_exc;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } exp_t;
  exp_t sb [$];

  function automatic logic [NC-1:0] model_mask(int unsigned px, int unsigned py, bit incl);
    logic [NC-1:0] m;
    longint dx, dy, sum, r2, rin2;
    bit hit;
    m = '0;
    for (int i = 0; i < NC; i++) begin
      dx   = longint'(px) - longint'(m_cx[i]);
      dy   = longint'(py) - longint'(m_cy[i]);
      sum  = dx * dx + dy * dy;
      r2   = longint'(m_r[i]) * longint'(m_r[i]);
      rin2 = longint'(m_rin[i]) * longint'(m_rin[i]);
      hit  = m_en[i] && (incl ? (sum <= r2) : (sum < r2));
`ifdef CIRCLE_RING_EN
      hit  = hit && (sum > rin2);
`else
      if (rin2 < 0) hit = 1'b0;  // inner radius has no effect without the ring
`endif
      m[i] = hit;
    end
    return m;
  endfunction

  function automatic int first_of(logic [NC-1:0] m);
    int f = -1;
    for (int i = 0; i < NC; i++) if (m[i] && f < 0) f = i;
    return (f < 0) ? 0 : f;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NC; i++) begin
      m_cx[i] = 0; m_cy[i] = 0; m_r[i] = 0; m_rin[i] = 0; m_en[i] = 1'b0;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit            prev_stall = 1'b0;
  logic [NC-1:0] prev_mask;
  logic [CW-1:0] prev_x, prev_y;

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_inc", if_inc.in_ready, !(if_inc.out_valid && !out_ready));
      check("in_ready_exc", if_exc.in_ready, !(if_exc.out_valid && !out_ready));
      if (prev_stall) begin
        check("hold_valid", if_inc.out_valid, 1);
        check("hold_mask", if_inc.out_hit_mask, prev_mask);
        check("hold_xy", {if_inc.out_x, if_inc.out_y}, {prev_x, prev_y});
      end
      prev_stall = if_inc.out_valid && !out_ready;
      prev_mask  = if_inc.out_hit_mask;
      prev_x     = if_inc.out_x;
      prev_y     = if_inc.out_y;

      if (if_inc.out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("mask_inc", if_inc.out_hit_mask, e.mask_inc);
          check("any_inc", if_inc.out_any, |e.mask_inc);
          check("first_inc", if_inc.out_first_idx, first_of(e.mask_inc));
          check("x_inc", if_inc.out_x, e.x);
          check("y_inc", if_inc.out_y, e.y);
          check("valid_exc", if_exc.out_valid, 1);
          check("mask_exc", if_exc.out_hit_mask, e.mask_exc);
          check("any_exc", if_exc.out_any, |e.mask_exc);
          check("first_exc", if_exc.out_first_idx, first_of(e.mask_exc));
          check("xy_exc", {if_exc.out_x, if_exc.out_y}, {e.x, e.y});
        end
      end

      // Acceptance uses the table before this cycle's write takes effect.
      if (in_valid && if_inc.in_ready) begin
        e.mask_inc = model_mask(in_x, in_y, 1'b1);
        e.mask_exc = model_mask(in_x, in_y, 1'b0);
        e.x = in_x;
        e.y = in_y;
        sb.push_back(e);
      end
      if (cfg_we && int'(cfg_idx) < NC) begin
        m_cx[cfg_idx] = cfg_x; m_cy[cfg_idx] = cfg_y; m_r[cfg_idx] = cfg_r;
        m_rin[cfg_idx] = cfg_rin; m_en[cfg_idx] = cfg_en;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int idx, input int x, input int y, input int r, input int rin, input bit en);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_x = CW'(x); cfg_y = CW'(y);
    cfg_r = CW'(r); cfg_rin = CW'(rin); cfg_en = en;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Sends one pixel on an idle pipe and checks the 3-cycle latency plus the
  // expected masks. With we=1, entry0 is rewritten in the acceptance cycle.
  task automatic send_px(input string tag, input int x, input int y,
                         input logic [NC-1:0] exp_inc, input logic [NC-1:0] exp_exc,
                         input bit we, input int new_r);
    @(posedge clk); #1;
    in_valid = 1'b1; in_x = CW'(x); in_y = CW'(y);
    if (we) begin
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_x = CW'(100); cfg_y = CW'(100);
      cfg_r = CW'(new_r); cfg_rin = '0; cfg_en = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    @(negedge clk); check({tag, "_lat1"}, if_inc.out_valid, 0);
    @(negedge clk); check({tag, "_lat2"}, if_inc.out_valid, 0);
    @(negedge clk); check({tag, "_lat3"}, if_inc.out_valid, 1);
    check({tag, "_inc"}, if_inc.out_hit_mask, exp_inc);
    check({tag, "_exc"}, if_exc.out_hit_mask, exp_exc);
    check({tag, "_first"}, if_inc.out_first_idx, first_of(exp_inc));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {if_inc.out_valid, if_exc.out_valid}, 0);
    check({tag, "_mask"}, if_inc.out_hit_mask, 0);
    check({tag, "_any_first"}, {if_inc.out_any, if_inc.out_first_idx}, 0);
    check({tag, "_xy"}, {if_inc.out_x, if_inc.out_y}, 0);
    check({tag, "_in_ready"}, if_inc.in_ready, 1);
  endtask

  function automatic logic [CW-1:0] rnd_coord();
    if ($urandom_range(15) == 0) return CW'(4095 - $urandom_range(3));
    return CW'($urandom_range(80));
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    @(negedge clk);
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [CW-1:0] b2b_x [8];
    bit acc;
    int px, c;

    clear_model();
    #12;
    check_reset_state("reset");
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); check_reset_state("post_reset");

    // d^2 exactly equals r^2: inclusive hits, exclusive does not
    wr(0, 100, 100, 10, 0, 1'b1);
    send_px("edge_r", 106, 108, 4'b0001, 4'b0000, 1'b0, 0);
    // two overlapping circles, lowest index reported
    wr(1, 50, 50, 5, 0, 1'b1);
    wr(3, 52, 50, 5, 0, 1'b1);
    send_px("two_hit", 51, 50, 4'b1010, 4'b1010, 1'b0, 0);
    send_px("no_hit", 0, 0, 4'b0000, 4'b0000, 1'b0, 0);
    check("no_hit_any", if_inc.out_any, 0);
    // extremes
    wr(0, 0, 0, 4095, 0, 1'b1);
    wr(1, 0, 0, 0, 0, 1'b0);
    wr(3, 0, 0, 0, 0, 1'b0);
    send_px("far_corner", 4095, 4095, 4'b0000, 4'b0000, 1'b0, 0);
    send_px("max_edge", 4095, 0, 4'b0001, 4'b0000, 1'b0, 0);
    // zero radius at entry2
    wr(2, 20, 20, 0, 0, 1'b1);
`ifdef CIRCLE_RING_EN
    send_px("r_zero", 20, 20, 4'b0001, 4'b0001, 1'b0, 0);
`else
    send_px("r_zero", 20, 20, 4'b0101, 4'b0001, 1'b0, 0);
`endif
    // same-cycle rewrite: old radius used, next pixel sees the new one
    wr(0, 100, 100, 10, 0, 1'b1);
    wr(2, 0, 0, 0, 0, 1'b0);
    send_px("snap_old", 105, 100, 4'b0001, 4'b0001, 1'b1, 1);
    send_px("snap_new", 105, 100, 4'b0000, 4'b0000, 1'b0, 0);
`ifdef CIRCLE_RING_EN
    wr(0, 100, 100, 10, 5, 1'b1);
    send_px("ring_in", 103, 100, 4'b0000, 4'b0000, 1'b0, 0);
    send_px("ring_out", 107, 100, 4'b0001, 4'b0001, 1'b0, 0);
`endif

    // 8 back-to-back pixels with out_ready low in cycles 2..4
    wr(1, 50, 50, 5, 0, 1'b1);
    for (int i = 0; i < 8; i++) b2b_x[i] = CW'(44 + 2 * i);
    @(posedge clk); #1;
    px = 0; c = 0;
    in_valid = 1'b1; in_x = b2b_x[0]; in_y = CW'(50);
    while (px < 8 && c < 100) begin
      @(negedge clk); acc = in_valid && if_inc.in_ready;
      @(posedge clk); #1; c++;
      if (acc) px++;
      if (px < 8) in_x = b2b_x[px]; else in_valid = 1'b0;
      out_ready = !(c >= 2 && c <= 4);
    end
    check("b2b_sent", px, 8);
    drain("b2b");

    // randomized traffic with back-pressure and live table rewrites
    for (int i = 0; i < NC; i++) wr(i, rnd_coord(), rnd_coord(), $urandom_range(40), $urandom_range(8), 1'b1);
    for (int n = 0; n < 600; n++) begin
      @(negedge clk); acc = in_valid && if_inc.in_ready;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(9) < 7);
        in_x = rnd_coord(); in_y = rnd_coord();
      end
      out_ready = ($urandom_range(9) < 7);
      cfg_we = ($urandom_range(9) == 0);
      cfg_idx = 2'($urandom_range(3));
      cfg_x = rnd_coord(); cfg_y = rnd_coord();
      cfg_r = ($urandom_range(19) == 0) ? CW'(4095) : CW'($urandom_range(40));
      cfg_rin = CW'($urandom_range(10));
      cfg_en = ($urandom_range(7) != 0);
    end
    @(posedge clk); #1; cfg_we = 1'b0;
    drain("rand");

    // reset with pixels in flight
    @(posedge clk); #1;
    in_valid = 1'b1; in_x = CW'(50); in_y = CW'(50);
    @(posedge clk); #1; in_x = CW'(51);
    @(posedge clk); #1; in_x = CW'(52);
    @(posedge clk); #1; in_valid = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check_reset_state("mid_reset");
    sb.delete();
    clear_model();
    @(posedge clk); @(posedge clk); #3 resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); check("post_rst_idle", {if_inc.out_valid, if_exc.out_valid}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
